// File: rtl/tl_port_arbiter.sv
// tl_port_arbiter: shares one TileLink-UL port between two requesters.
// Round-robin A mux with one hold stage; D routed back by source[5].
module tl_port_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int A_W = 83,
  parameter int D_W = 48
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [1:0]       m_a_valid,
  output logic [1:0]       m_a_ready,
  input  logic [2*A_W-1:0] m_a_bits,
  output logic [1:0]       m_d_valid,
  input  logic [1:0]       m_d_ready,
  output logic [D_W-1:0]   m_d_bits,
  output logic             tl_a_valid,
  input  logic             tl_a_ready,
  output logic [A_W:0]     tl_a_bits,
  input  logic             tl_d_valid,
  output logic             tl_d_ready,
  input  logic [D_W:0]     tl_d_bits,
  output logic             busy,
  output logic             err_unexpected_d
);

  // tag bit sits just above the requester's 5-bit source
  localparam int A_TAG = A_W - 9;
  localparam int D_TAG = D_W - 8;
  localparam logic [3:0] LIMIT = 4'(MAX_OUT);

  logic            hold_valid;
  logic [A_W:0]    hold_bits;
  logic            ptr;
  logic [1:0][3:0] cnt;
  logic [1:0]      elig;
  logic            slot_free;
  logic            gnt_vld;
  logic            gnt_idx;
  logic [A_W-1:0]  gnt_bits;
  logic            d_idx;
  logic            d_hs;
  logic [1:0]      inc;
  logic [1:0]      dec;
  logic            unexp;

  assign elig[0] = m_a_valid[0] && (cnt[0] < LIMIT);
  assign elig[1] = m_a_valid[1] && (cnt[1] < LIMIT);
  assign slot_free = !hold_valid || tl_a_ready;

  // pick an eligible requester; the pointer side wins ties
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    if (slot_free) begin
      if (elig[ptr]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr;
      end else if (elig[~ptr]) begin
        gnt_vld = 1'b1;
        gnt_idx = ~ptr;
      end
    end
  end

  assign m_a_ready = {gnt_vld & gnt_idx, gnt_vld & ~gnt_idx};
  assign gnt_bits  = gnt_idx ? m_a_bits[A_W +: A_W]
                             : m_a_bits[0 +: A_W];

  // output hold stage and round-robin pointer
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_bits  <= '0;
      ptr        <= 1'b0;
    end else if (gnt_vld) begin
      hold_valid <= 1'b1;
      hold_bits  <= {gnt_bits[A_W-1:A_TAG], gnt_idx,
                     gnt_bits[A_TAG-1:0]};
      ptr        <= ~gnt_idx;
    end else if (tl_a_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign tl_a_valid = hold_valid;
  assign tl_a_bits  = hold_bits;

  assign d_idx      = tl_d_bits[D_TAG];
  assign tl_d_ready = m_d_ready[d_idx];
  assign d_hs       = tl_d_valid && tl_d_ready;
  assign m_d_valid  = {tl_d_valid & d_idx, tl_d_valid & ~d_idx};
  assign m_d_bits   = {tl_d_bits[D_W:D_TAG+1],
                       tl_d_bits[D_TAG-1:0]};

  // a response to an idle requester never decrements
  assign inc      = m_a_ready;
  assign dec[0]   = d_hs && !d_idx && (cnt[0] != 4'd0);
  assign dec[1]   = d_hs && d_idx && (cnt[1] != 4'd0);
  assign unexp    = d_hs && (cnt[d_idx] == 4'd0);

  // outstanding counters and sticky error
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      err_unexpected_d <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + 4'd1;
        else if (dec[i] && !inc[i])
          cnt[i] <= cnt[i] - 4'd1;
      end
      if (unexp)
        err_unexpected_d <= 1'b1;
    end
  end

  assign busy = hold_valid || (|cnt);

endmodule
